// File: rtl/lpf_sched_pkg.sv
// lpf_sched_pkg: shared widths and types for the time-shared lowpass scheduler
package lpf_sched_pkg;
  localparam int DW = 13;
  localparam int AW = 17;
  localparam int FB_SHIFT = 3;
  localparam int OUT_SHIFT = 4;
  typedef logic signed [DW-1:0] sample_t;
  typedef logic signed [AW-1:0] acc_t;
endpackage

// File: rtl/lpf_step.sv
// lpf_step: one combinational update of H(z)=(z+1)/(16z-14), acc holds 16x the output
module lpf_step
  import lpf_sched_pkg::*;
(
  input  sample_t x,
  input  sample_t in_1,
  input  acc_t    acc,
  output acc_t    next_acc,
  output sample_t y
);
  assign next_acc = acc_t'(x) + acc_t'(in_1) + acc - (acc >>> FB_SHIFT);
  assign y = next_acc[AW-1:OUT_SHIFT];
endmodule

// File: rtl/lpf_share_sched.sv
// lpf_share_sched: round-robin sharing of one lowpass step across NCH channels
module lpf_share_sched
  import lpf_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CHW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    in_valid,
  input  logic [DW*NCH-1:0] in_data,
  output logic [NCH-1:0]    in_ready,
  input  logic [NCH-1:0]    flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CHW-1:0]    out_ch,
  output logic [DW-1:0]     out_data
);
  acc_t acc [NCH];
  sample_t in1 [NCH];
  sample_t xs [NCH];
  logic [CHW-1:0] ptr, g, idx;
  logic hit, stall, fire;
  acc_t nacc;
  sample_t y;
  for (genvar i = 0; i < NCH; i++) begin : g_split
    assign xs[i] = in_data[DW*i +: DW];
  end
  assign stall = out_valid & ~out_ready;
  always_comb begin
    g = '0;
    hit = 1'b0;
    idx = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = CHW'((int'(ptr) + k) % NCH);
      if (!hit && in_valid[idx] && !flush[idx]) begin
        hit = 1'b1;
        g = idx;
      end
    end
  end
  assign fire = hit & ~stall & ~rst;
  assign in_ready = fire ? NCH'(1) << g : '0;
  lpf_step u_step (
    .x(xs[g]),
    .in_1(in1[g]),
    .acc(acc[g]),
    .next_acc(nacc),
    .y(y)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        acc[i] <= '0;
        in1[i] <= '0;
      end
      ptr <= '0;
      out_valid <= 1'b0;
      out_ch <= '0;
      out_data <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (flush[i]) begin
          acc[i] <= '0;
          in1[i] <= '0;
        end else if (fire && g == CHW'(i)) begin
          acc[i] <= nacc;
          in1[i] <= xs[i];
        end
      end
      if (fire) begin
        out_valid <= 1'b1;
        out_ch <= g;
        out_data <= y;
        ptr <= (g == CHW'(NCH-1)) ? '0 : g + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_lpf_share_sched.sv
// tb_lpf_share_sched: directed table plus model-checked round-robin sequences
module tb_lpf_share_sched;
  import lpf_sched_pkg::*;
  localparam int N = 4;
  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] f;
    logic ordy;
    logic [N-1:0] rdy;
    logic ov;
    int ch;
    int dat;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] in_valid = '0, in_ready, flush = '0;
  logic [DW*N-1:0] in_data = '0;
  logic out_valid, out_ready = 1'b1;
  logic [1:0] out_ch;
  logic [DW-1:0] out_data;
  int tests = 0, fails = 0;
  int macc[N], min1[N], mptr, mch, md;
  logic mv;
  logic [N-1:0][DW-1:0] D;
  vec_t tab[13];
  always #5 clk = ~clk;
  lpf_share_sched #(.NCH(N), .CHW(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data)
  );
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic int fdiv(input int a, input int b);
    int q = a / b;
    if (a < 0 && a % b != 0) q--;
    return q;
  endfunction
  function automatic int wrap17(input int a);
    return ((a + 65536) % 131072 + 131072) % 131072 - 65536;
  endfunction
  task automatic apply(input logic [N-1:0] v, input logic [N-1:0] f, input logic ordy);
    in_valid = v;
    flush = f;
    in_data = D;
    out_ready = ordy;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    apply('0, '0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      macc[i] = 0;
      min1[i] = 0;
    end
    mptr = 0; mv = 1'b0; mch = 0; md = 0;
  endtask
  task automatic mcycle(input string nm, input logic [N-1:0] v, input logic [N-1:0] f, input logic ordy);
    int g = -1;
    int x, t, c;
    logic [N-1:0] er = '0;
    apply(v, f, ordy);
    #1;
    if (!(mv && !ordy))
      for (int k = 0; k < N; k++) begin
        c = (mptr + k) % N;
        if (g < 0 && v[c] && !f[c]) g = c;
      end
    if (g >= 0) er[g] = 1'b1;
    chk({nm, " rdy"}, int'(in_ready), int'(er));
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (f[i]) begin
        macc[i] = 0;
        min1[i] = 0;
      end
    if (g >= 0) begin
      x = int'($signed(D[g]));
      t = wrap17(x + min1[g] + macc[g] - fdiv(macc[g], 8));
      macc[g] = t;
      min1[g] = x;
      mv = 1'b1; mch = g; md = fdiv(t, 16);
      mptr = (g + 1) % N;
    end else if (ordy) mv = 1'b0;
    chk({nm, " ov"}, int'(out_valid), int'(mv));
    if (mv) begin
      chk({nm, " ch"}, int'(out_ch), mch);
      chk({nm, " data"}, int'($signed(out_data)), md);
    end
  endtask
  initial begin
    int lastd[N];
    logic done;
    D = {13'sd4095, 13'sd1000, -13'sd4096, 13'sd1000};
    tab[0]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 0};
    tab[1]  = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 0, 62};
    tab[2]  = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 0, 179};
    tab[3]  = '{4'b0011, 4'b0000, 1'b1, 4'b0010, 1'b1, 1, -256};
    tab[4]  = '{4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b1, 0, 282};
    tab[5]  = '{4'b0011, 4'b0010, 1'b1, 4'b0001, 1'b1, 0, 372};
    tab[6]  = '{4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 1, -256};
    tab[7]  = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b1, 1, -256};
    tab[8]  = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b1, 1, -256};
    tab[9]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1, -256};
    tab[10] = '{4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b1, 3, 255};
    tab[11] = '{4'b1100, 4'b0000, 1'b1, 4'b0100, 1'b1, 2, 62};
    tab[12] = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 0, 450};
    #2;
    chk("rst ov", int'(out_valid), 0);
    chk("rst rdy", int'(in_ready), 0);
    do_reset();
    for (int i = 0; i < 13; i++) begin
      apply(tab[i].v, tab[i].f, tab[i].ordy);
      #1;
      chk($sformatf("t%0d rdy", i), int'(in_ready), int'(tab[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("t%0d ov", i), int'(out_valid), int'(tab[i].ov));
      chk($sformatf("t%0d ch", i), int'(out_ch), tab[i].ch);
      chk($sformatf("t%0d data", i), int'($signed(out_data)), tab[i].dat);
    end
    do_reset();
    done = 1'b0;
    for (int i = 0; i < N; i++) lastd[i] = 0;
    for (int c = 0; c < 500; c++) begin
      mcycle("rr", 4'hF, (c == 450) ? 4'h4 : 4'h0, !(c >= 40 && c < 45));
      if (out_valid) begin
        if (c > 450 && out_ch == 2'd2 && !done) begin
          chk("flush ch2 restart", int'($signed(out_data)), 62);
          done = 1'b1;
        end
        lastd[out_ch] = int'($signed(out_data));
      end
      if (c == 440) begin
        chk("conv ch0", lastd[0], 1000);
        chk("conv ch1", lastd[1], -4096);
        chk("conv ch2", lastd[2], 1000);
        chk("conv ch3", lastd[3], 4095);
      end
    end
    chk("flush ch2 seen", int'(done), 1);
    chk("pre-rst ov", int'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid rst ov", int'(out_valid), 0);
    chk("mid rst rdy", int'(in_ready), 0);
    chk("mid rst data", int'(out_data), 0);
    chk("mid rst ch", int'(out_ch), 0);
    do_reset();
    mcycle("post", 4'b0001, 4'b0000, 1'b1);
    chk("post rst ch0", int'($signed(out_data)), 62);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lpf_share_sched.md
Name: lpf_share_sched

Overview:
- Time-multiplexes one first-order lowpass datapath, H(z) = (z+1)/(16z-14), across NCH independent 13-bit signed channels of the frequency-locking loop.
- Each channel keeps private filter state: a 17-bit accumulator (16 x output) and its previous input.
- Requesters present samples with valid/ready handshakes.
- A round-robin arbiter grants one sample per clock to the shared update step.
- Filtered results leave on a single tagged output stream that honours backpressure.

Parameters:
- NCH, 4, number of channels (2..8).
- CHW, 2, channel-index width, = clog2(NCH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  NCH  per-channel sample valid.
- in_data  in  13*NCH  per-channel signed sample; channel i occupies bits [13i+12:13i].
- in_ready  out  NCH  per-channel accept; one-hot or zero.
- flush  in  NCH  per-channel state clear, single-cycle pulse.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_ch  out  CHW  channel index of the result.
- out_data  out  13  signed filtered result.

Behaviour:
- Reset (async, rst=1):
  - All acc[i] and in_1[i] are cleared to 0.
  - The round-robin pointer is set to 0.
  - out_valid=0, out_ch=0, out_data=0.
  - in_ready=0 while rst is high.
  - Reset asserted mid-transfer drops the pending output; there is no partial state update.
- stall = out_valid & ~out_ready.
  - While stalled: in_ready is all zero, and out_valid, out_ch and out_data hold.
- Grant (combinational, from registered state):
  - Eligible channels: in_valid[i] & ~flush[i].
  - Search from pointer, ascending with wrap; the first eligible channel g gets in_ready[g]=1.
  - No grant is issued when stalled or when no channel is eligible.
- Update on a clk edge where in_valid[g] & in_ready[g]:
  - temp = sext17(x) + sext17(in_1[g]) + acc[g] - (acc[g] >>> 3), where x is the sample.
  - Arithmetic is modulo 2^17 with two's-complement wrap and no saturation.
  - acc[g] <= temp.
  - in_1[g] <= x.
  - out_data <= temp[16:4] (floor division by 16).
  - out_ch <= g, out_valid <= 1.
  - Pointer <= g+1, wrapping to 0 when g = NCH-1.
- Output completion: if the current output is accepted and no new grant occurs, out_valid <= 0. An accept and a new grant in the same cycle reload the output without a bubble.
- Latency: sample accepted at edge k; its result is visible with out_valid=1 after edge k. Sustained throughput is one sample per clock when out_ready=1.
- Flush:
  - flush[i] clears acc[i] and in_1[i] at the next edge.
  - It overrides a grant: a flushed channel is never granted in that cycle.
  - Flush of one channel never disturbs other channels or the output register.
- DC gain is 1; steady-state out_data equals a constant input. Full range -4096..4095 fits acc without wrap in steady state.

Decomposition:
- Shared package lpf_sched_pkg holds:
  - Constants DW=13, AW=17, FB_SHIFT=3, OUT_SHIFT=4.
  - Type sample_t (signed [12:0]) and type acc_t (signed [16:0]).
- One natural sub-module, lpf_step: purely combinational.
  - Inputs: x, in_1, acc.
  - Outputs: next_acc and its [16:4] slice.
  - Instantiated once and fed from the state bank through a grant-indexed mux.

Test Plan:
- Ch0 only, in_data=1000 held, out_ready=1, from reset -> out_data 62, 179, then monotonically rising, converging to exactly 1000 (acc=16000); out_ch=0 throughout.
- All NCH=4 channels valid every cycle, out_ready=1 -> grants and out_ch sequence 0,1,2,3,0,1..., one result per clock; each channel's trajectory equals its single-channel reference.
- out_ready=0 for 5 cycles while results are pending -> in_ready=0, outputs frozen, no state change; resumption continues the round-robin at the pointer.
- Ch2 converged at 1000, then flush[2] pulsed while in_valid[2]=1 -> ch2 not granted that cycle; the next ch2 sample 1000 yields 62; other channels unaffected.
- Ch1 constant -4096 -> converges to out_data=-4096, acc=-65536 with no wrap; ch3 constant 4095 -> converges to 4095.
- rst asserted mid-stream with out_valid=1 -> out_valid=0 immediately (async); after release, the first ch0 sample 1000 yields 62.
